// File: rtl/cnt_extender.sv
// Extends a free-running 4-bit ripple counter into a (4+EXT_W)-bit count by
// synchronising, glitch-filtering and tracking its 15<->0 wrap-arounds.
module cnt_extender #(
    parameter int EXT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         cnt_in,
    input  logic               clr,
    output logic [4+EXT_W-1:0] count_out,
    output logic               count_vld,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic               evt_dir,
    output logic               evt_drop,
    output logic               err_skip,
    output logic               ovf
);

    localparam logic [EXT_W-1:0] EXT_ONE = EXT_W'(1'b1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Synchroniser / filter registers
    logic [3:0]       s1_q;
    logic [3:0]       s2_q;
    logic [3:0]       p_q;
    logic [2:0]       fill_q;
    logic             smp_vld_q;
    logic [3:0]       smp_q;
    logic             stable;

    // Tracking state
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       lower_q;
    logic [3:0]       lower_d;
    logic [EXT_W-1:0] upper_q;
    logic [EXT_W-1:0] upper_d;
    logic             vld_q;
    logic             vld_d;
    logic             skip_q;
    logic             skip_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             evt_valid_q;
    logic             evt_valid_d;
    logic             evt_dir_q;
    logic             evt_dir_d;
    logic             drop_q;
    logic             drop_d;

    logic             wrap;
    logic             wrap_dir;
    logic             xfer;
    logic [3:0]       lower_inc;
    logic [3:0]       lower_dec;

    // fill_q marks which pipeline stages hold a real sample since reset, so the
    // cleared zeros are never mistaken for a stable count of 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1_q      <= 4'd0;
            s2_q      <= 4'd0;
            p_q       <= 4'd0;
            fill_q    <= 3'b000;
            smp_vld_q <= 1'b0;
            smp_q     <= 4'd0;
        end else begin
            s1_q      <= cnt_in;
            s2_q      <= s1_q;
            p_q       <= s2_q;
            fill_q    <= {fill_q[1:0], 1'b1};
            smp_vld_q <= stable;
            smp_q     <= s2_q;
        end
    end

    assign stable    = fill_q[2] && fill_q[1] && (s2_q == p_q);
    assign lower_inc = lower_q + 4'd1;
    assign lower_dec = lower_q - 4'd1;
    assign xfer      = evt_valid_q && evt_ready;

    // Classify each filtered sample against the last accepted value.
    always_comb begin
        state_d  = state_q;
        lower_d  = lower_q;
        upper_d  = upper_q;
        vld_d    = vld_q;
        skip_d   = skip_q;
        ovf_d    = ovf_q;
        wrap     = 1'b0;
        wrap_dir = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (smp_vld_q) begin
                    lower_d = smp_q;
                    upper_d = '0;
                    vld_d   = 1'b1;
                    state_d = ST_TRACK;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_TRACK: begin
                if (smp_vld_q && (smp_q != lower_q)) begin
                    lower_d = smp_q;
                    if (smp_q == lower_inc) begin
                        if (lower_q == 4'd15) begin
                            upper_d  = upper_q + EXT_ONE;
                            wrap     = 1'b1;
                            wrap_dir = 1'b0;
                            if (&upper_q) begin
                                ovf_d = 1'b1;
                            end else begin
                                ovf_d = ovf_q;
                            end
                        end else begin
                            upper_d = upper_q;
                        end
                    end else if (smp_q == lower_dec) begin
                        if (lower_q == 4'd0) begin
                            upper_d  = upper_q - EXT_ONE;
                            wrap     = 1'b1;
                            wrap_dir = 1'b1;
                            if (upper_q == '0) begin
                                ovf_d = 1'b1;
                            end else begin
                                ovf_d = ovf_q;
                            end
                        end else begin
                            upper_d = upper_q;
                        end
                    end else begin
                        skip_d = 1'b1;
                    end
                end else begin
                    state_d = ST_TRACK;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // A new wrap may replace the payload only if the slot is empty or draining this cycle.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_dir_d   = evt_dir_q;
        drop_d      = drop_q;
        if (wrap) begin
            if (!evt_valid_q || xfer) begin
                evt_valid_d = 1'b1;
                evt_dir_d   = wrap_dir;
            end else begin
                drop_d = 1'b1;
            end
        end else if (xfer) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end
    end

    // Tracking FSM with all outputs held in registers.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= ST_INIT;
            lower_q     <= 4'd0;
            upper_q     <= '0;
            vld_q       <= 1'b0;
            skip_q      <= 1'b0;
            ovf_q       <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_dir_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lower_q     <= lower_d;
            upper_q     <= upper_d;
            vld_q       <= vld_d;
            skip_q      <= skip_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_dir_q   <= evt_dir_d;
            drop_q      <= drop_d;
        end
    end

    assign count_out = {upper_q, lower_q};
    assign count_vld = vld_q;
    assign evt_valid = evt_valid_q;
    assign evt_dir   = evt_dir_q;
    assign evt_drop  = drop_q;
    assign err_skip  = skip_q;
    assign ovf       = ovf_q;

endmodule
